// File: rtl/imu_cfg_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imu_cfg_rd_ctrl -- IMU power-up/config writer and yaw-rate reader (SPI)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module imu_cfg_rd_ctrl #(
  parameter int          PWRUP_W = 16,
  parameter logic [15:0] CFG0    = 16'h0D02,
  parameter logic [15:0] CFG1    = 16'h1053,
  parameter logic [15:0] CFG2    = 16'h1150,
  parameter logic [15:0] CFG3    = 16'h1460,
  parameter logic [15:0] RD_YL   = 16'hA600,
  parameter logic [15:0] RD_YH   = 16'hA700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    PWRUP  = 3'd0,
    CFG    = 3'd1,
    CWAIT  = 3'd2,
    IDLE   = 3'd3,
    RLWAIT = 3'd4,
    RHWAIT = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [PWRUP_W-1:0] timer, timer_nxt;
  logic [1:0]         idx, idx_nxt;
  logic               blank, blank_nxt;
  logic [7:0]         yl, yl_nxt;
  logic               int_s1, int_s2, int_s3;
  logic               pending, pending_nxt;
  logic               rise, start_rd;
  logic               wrt_nxt, vld_nxt, init_nxt;
  logic [15:0]        cmd_nxt, yaw_nxt;
  logic               unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  function automatic logic [15:0] cfg_word(input logic [1:0] i);
    case (i)
      2'd0:    cfg_word = CFG0;
      2'd1:    cfg_word = CFG1;
      2'd2:    cfg_word = CFG2;
      default: cfg_word = CFG3;
    endcase
  endfunction

  assign rise = int_s2 & ~int_s3;

  // A rise coinciding with the start of a read must survive, so set wins
  assign pending_nxt = rise | (pending & ~start_rd);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    blank_nxt = 1'b0;
    yl_nxt    = yl;
    wrt_nxt   = 1'b0;
    cmd_nxt   = cmd;
    yaw_nxt   = yaw_rt;
    vld_nxt   = 1'b0;
    init_nxt  = init_done;
    start_rd  = 1'b0;

    case (state)
      PWRUP: begin
        timer_nxt = timer + 1'b1;
        if (&timer) begin
          state_nxt = CFG;
          idx_nxt   = 2'd0;
          wrt_nxt   = 1'b1;
          cmd_nxt   = cfg_word(2'd0);
        end
      end

      CFG: begin
        state_nxt = CWAIT;
        blank_nxt = 1'b1;
      end

      // The first wait cycle may still see done from the previous transfer
      CWAIT: begin
        if (!blank && done) begin
          if (idx == 2'd3) begin
            init_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = CFG;
            wrt_nxt   = 1'b1;
            cmd_nxt   = cfg_word(idx + 2'd1);
          end
        end
      end

      IDLE: begin
        if (pending) begin
          start_rd  = 1'b1;
          cmd_nxt   = RD_YL;
          wrt_nxt   = 1'b1;
          blank_nxt = 1'b1;
          state_nxt = RLWAIT;
        end
      end

      RLWAIT: begin
        if (!blank && done) begin
          yl_nxt    = rd_data[7:0];
          cmd_nxt   = RD_YH;
          wrt_nxt   = 1'b1;
          blank_nxt = 1'b1;
          state_nxt = RHWAIT;
        end
      end

      RHWAIT: begin
        if (!blank && done) begin
          yaw_nxt   = {rd_data[7:0], yl};
          vld_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      timer     <= '0;
      idx       <= 2'd0;
      blank     <= 1'b0;
      yl        <= 8'h00;
      int_s1    <= 1'b0;
      int_s2    <= 1'b0;
      int_s3    <= 1'b0;
      pending   <= 1'b0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      yaw_rt    <= 16'h0000;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      blank     <= blank_nxt;
      yl        <= yl_nxt;
      int_s1    <= INT;
      int_s2    <= int_s1;
      int_s3    <= int_s2;
      pending   <= pending_nxt;
      wrt       <= wrt_nxt;
      cmd       <= cmd_nxt;
      yaw_rt    <= yaw_nxt;
      vld       <= vld_nxt;
      init_done <= init_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imu_cfg_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imu_cfg_rd_ctrl -- bench with SPI responder model and yaw scoreboard     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_imu_cfg_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  logic        spi_done = 1'b0;
  logic        stuck_hi = 1'b0;
  assign done = spi_done | stuck_hi;

  int errors = 0;
  int checks = 0;

  imu_cfg_rd_ctrl #(.PWRUP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected command stream: four config words, then alternating yaw reads
  logic [15:0] cfg_tab [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  function automatic logic [15:0] exp_cmd(input int n);
    if (n < 4) return cfg_tab[n];
    return ((n - 4) % 2 == 0) ? 16'hA600 : 16'hA700;
  endfunction

  // SPI responder: acts 2 time units after each rising edge
  int          lat = 32;
  int          wrt_cnt = 0;
  logic [7:0]  resp_lo = 8'h00, resp_hi = 8'h00;
  initial begin : spi_model
    int cnt;
    bit busy;
    logic [15:0] cur;
    busy = 0; cnt = 0; cur = 16'h0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        busy = 0; spi_done = 1'b0; wrt_cnt = 0;
      end else if (wrt) begin
        chk("cmd_seq", cmd, exp_cmd(wrt_cnt));
        wrt_cnt++;
        cur = cmd; busy = 1; cnt = lat; spi_done = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0;
          spi_done = 1'b1;
          chk("cmd_stable", cmd, cur);
          if (cur == 16'hA600)      rd_data = {8'($urandom), resp_lo};
          else if (cur == 16'hA700) rd_data = {8'($urandom), resp_hi};
          else                      rd_data = 16'($urandom);
        end
      end
    end
  end

  // Protocol monitor
  int wrt_viol = 0, vld_viol = 0, yaw_viol = 0, vld_cnt = 0;
  initial begin : monitor
    logic pw, pv;
    logic [15:0] py;
    pw = 0; pv = 0; py = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wrt && pw) wrt_viol++;
        if (vld && pv) vld_viol++;
        if (yaw_rt != py && !vld) yaw_viol++;
        if (vld) vld_cnt++;
      end
      pw = wrt; pv = vld; py = yaw_rt;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic wait_vld(input int max, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (vld) ok = 1;
    end
    if (!ok) chk({name, "_vld_timeout"}, 0, 1);
  endtask

  task automatic wait_init(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (init_done) ok = 1;
    end
    if (!ok) chk("init_timeout", 0, 1);
  endtask

  task automatic wait_wrt_cmd(input logic [15:0] c, input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (wrt && cmd == c) ok = 1;
    end
    if (!ok) chk("wrt_cmd_timeout", 0, 1);
  endtask

  task automatic pulse_int();
    @(negedge clk);
    INT = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    INT = 1'b0;
    stuck_hi = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct packed {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] yaw;
  } vec_t;

  initial begin : main
    vec_t tab [6];
    logic [15:0] exp_q [$];
    int n, w0, v0;
    bit seen;

    tab[0] = '{lo: 8'h34, hi: 8'hC2, yaw: 16'hC234};
    tab[1] = '{lo: 8'h00, hi: 8'h00, yaw: 16'h0000};
    tab[2] = '{lo: 8'hFF, hi: 8'h7F, yaw: 16'h7FFF};
    tab[3] = '{lo: 8'h00, hi: 8'h80, yaw: 16'h8000};
    tab[4] = '{lo: 8'hFF, hi: 8'hFF, yaw: 16'hFFFF};
    tab[5] = '{lo: 8'h01, hi: 8'h00, yaw: 16'h0001};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wrt", wrt, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_yaw", yaw_rt, 16'h0000);
    chk("rst_vld", vld, 0);
    chk("rst_init", init_done, 0);

    // Power-up wait then config sequence
    rst_n = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (wrt) seen = 1;
    end
    chk("first_wrt_cycle_ok", (seen && n >= 15 && n <= 17), 1);
    chk("first_cmd", cmd, 16'h0D02);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (wrt_cnt == 4 && spi_done) seen = 1;
    end
    chk("fourth_done_seen", seen, 1);
    chk("init_before_done", init_done, 0);
    @(negedge clk);
    chk("init_after_done", init_done, 1);

    // Table-driven read sequences
    for (int r = 0; r < 6; r++) begin
      resp_lo = tab[r].lo;
      resp_hi = tab[r].hi;
      pulse_int();
      wait_vld(300, "table");
      chk($sformatf("table%0d_yaw", r), yaw_rt, tab[r].yaw);
      @(negedge clk);
      chk($sformatf("table%0d_vld_width", r), vld, 0);
    end

    // Second INT rise while the high-byte read is outstanding
    resp_lo = 8'h5A; resp_hi = 8'hA5;
    w0 = wrt_cnt; v0 = vld_cnt;
    pulse_int();
    wait_wrt_cmd(16'hA700, 200);
    pulse_int();
    wait_vld(300, "rh_first");
    chk("rh_first_yaw", yaw_rt, 16'hA55A);
    wait_vld(300, "rh_second");
    chk("rh_second_yaw", yaw_rt, 16'hA55A);
    repeat (200) @(negedge clk);
    chk("rh_wrt_count", wrt_cnt - w0, 4);
    chk("rh_vld_count", vld_cnt - v0, 2);

    // done stuck high in IDLE with no INT
    stuck_hi = 1'b1;
    w0 = wrt_cnt; v0 = vld_cnt;
    repeat (1000) @(negedge clk);
    chk("stuck_wrt", wrt_cnt - w0, 0);
    chk("stuck_vld", vld_cnt - v0, 0);
    stuck_hi = 1'b0;

    // Randomized reads against a queue of expected yaw words
    for (int k = 0; k < 20; k++) begin
      lat = $urandom_range(1, 40);
      resp_lo = 8'($urandom);
      resp_hi = 8'($urandom);
      exp_q.push_back({resp_hi, resp_lo});
      pulse_int();
      wait_vld(300, "rand");
      chk($sformatf("rand%0d_yaw", k), yaw_rt, exp_q.pop_front());
    end
    lat = 32;
    repeat (10) @(negedge clk);

    // INT during power-up and config: serviced once after init
    apply_reset();
    rst_n = 1'b1;
    resp_lo = 8'h11; resp_hi = 8'h22;
    v0 = vld_cnt;
    repeat (3) @(negedge clk);
    pulse_int();
    wait_wrt_cmd(16'h1053, 200);
    pulse_int();
    wait_init(400);
    chk("cfgint_no_early_vld", vld_cnt - v0, 0);
    chk("cfgint_wrt_at_init", wrt_cnt, 4);
    wait_vld(300, "cfgint");
    chk("cfgint_yaw", yaw_rt, 16'h2211);
    repeat (200) @(negedge clk);
    chk("cfgint_wrt_total", wrt_cnt, 6);

    // Reset asserted during the low-byte read
    resp_lo = 8'h77; resp_hi = 8'h66;
    pulse_int();
    wait_wrt_cmd(16'hA600, 200);
    repeat (5) @(negedge clk);
    v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_wrt", wrt, 0);
    chk("midrst_init", init_done, 0);
    chk("midrst_yaw", yaw_rt, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init(400);
    chk("midrst_reconfig_wrts", wrt_cnt, 4);
    repeat (50) @(negedge clk);
    chk("midrst_no_vld", vld_cnt - v0, 0);
    chk("midrst_yaw_hold", yaw_rt, 16'h0000);

    chk("wrt_consecutive", wrt_viol, 0);
    chk("vld_multi_cycle", vld_viol, 0);
    chk("yaw_change_without_vld", yaw_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
